upsample_2x: RTL and testbench

UPSAMPLE_2X -- requirements
Module: upsample_2x

---
 rtl/upsample_2x_if.sv | 31 +++
 rtl/upsample_2x.sv | 161 ++++++++++++++++
 tb/tb_upsample_2x.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/upsample_2x_if.sv
// ---------------------------------------------------------------------------
// upsample_2x_if -- feature stream bundle for the 2x upsampler.
//
// Upstream side:   i_feature_valid, o_feature_ready, i_features
// Downstream side: o_feature_valid, i_feature_ready, o_features, o_frame_last
// Feature buses are 6 lanes x 8 bit. Each lane carries a two's-complement
// (signed) value; the block never does arithmetic on it, so the lanes are
// declared as plain bits.
//
// modport slave  : the upsampler itself
// modport master : whatever drives it (pooling stage + downstream consumer)
// ---------------------------------------------------------------------------
interface upsample_2x_if;
  logic            i_feature_valid;
  logic            o_feature_ready;
  logic [5:0][7:0] i_features;
  logic            o_feature_valid;
  logic            i_feature_ready;
  logic [5:0][7:0] o_features;
  logic            o_frame_last;

  modport slave (
    input  i_feature_valid, i_features, i_feature_ready,
    output o_feature_ready, o_feature_valid, o_features, o_frame_last
  );

  modport master (
    output i_feature_valid, i_features, i_feature_ready,
    input  o_feature_ready, o_feature_valid, o_features, o_frame_last
  );
endinterface

// File: rtl/upsample_2x.sv
// ---------------------------------------------------------------------------
// upsample_2x -- 2x upsampler, 14x14 -> 28x28 per channel, 6 channels in
// lockstep, valid/ready on both sides.
//
// Ports:
//   i_clk   : sole clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : upsample_2x_if.slave (feature in/out streams, o_frame_last)
//
// ROW_A forwards each accepted input twice (output cols 2c, 2c+1) and stores
// it in a 14-entry line buffer; ROW_B replays the buffer, each entry twice,
// to produce the odd output row. o_frame_last marks output (27,27).
//
// Build option: define UPSAMPLE_ZERO_FILL_EN for zero-stuffing instead of
// nearest-neighbour replication (input only at even row/even col, zeros
// elsewhere; no line buffer). Handshake and timing are identical.
// ---------------------------------------------------------------------------
module upsample_2x (
  input  logic         i_clk,
  input  logic         i_rst_n,
  upsample_2x_if.slave bus
);
  localparam logic [3:0] LAST_IDX = 4'd13;

  typedef enum logic { ROW_A, ROW_B } state_e;
  typedef logic [5:0][7:0] beat_t;

  state_e     state_q, state_d;
  logic [3:0] col_q, col_d;    // column of the next ROW_A accept
  logic       dup_q, dup_d;    // 0: first copy of a value, 1: second copy
  logic [3:0] rep_q, rep_d;    // line-buffer replay index in ROW_B
  logic [3:0] row_q, row_d;    // input row
  logic       out_valid_q, out_valid_d;
  beat_t      out_data_q, out_data_d;
  logic       out_last_q, out_last_d;

  logic  emit;
  logic  accept;
  logic  row_a_last_col;
  beat_t replay_data;

  assign emit = out_valid_q & bus.i_feature_ready;

  // col_q wraps to 0 once column 13 is accepted, so a valid ROW_A beat seen
  // with col_q == 0 is the final column of the row.
  assign row_a_last_col = (col_q == 4'd0);

  // New input may load only into an empty register or in the same cycle the
  // second copy leaves; never after column 13, whose second copy hands over
  // to ROW_B.
  assign bus.o_feature_ready = (state_q == ROW_A) &
                               (~out_valid_q | (dup_q & emit & ~row_a_last_col));
  assign accept = bus.i_feature_valid & bus.o_feature_ready;

`ifdef UPSAMPLE_ZERO_FILL_EN
  assign replay_data = '0;
`else
  beat_t      line_buf_q [14];
  logic [3:0] replay_idx;

  // Entry 0 is fetched while entering ROW_B; afterwards the next entry.
  assign replay_idx  = ((state_q == ROW_B) && (rep_q != LAST_IDX)) ? rep_q + 4'd1 : 4'd0;
  assign replay_data = line_buf_q[replay_idx];

  // NOTE: the line buffer is deliberately not reset: each entry is rewritten
  // in ROW_A before ROW_B reads it, and leaving it reset-free lets it map to
  // plain storage.
  always_ff @(posedge i_clk) begin
    if (accept) line_buf_q[col_q] <= bus.i_features;
  end
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // below leaves a variable unassigned (which would infer a latch).
    state_d     = state_q;
    col_d       = col_q;
    dup_d       = dup_q;
    rep_d       = rep_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      ROW_A: begin
        if (accept) begin
          out_data_d  = bus.i_features;
          out_valid_d = 1'b1;
          dup_d       = 1'b0;
          col_d       = (col_q == LAST_IDX) ? 4'd0 : col_q + 4'd1;
        end else if (emit) begin
          if (!dup_q) begin
            dup_d = 1'b1;
`ifdef UPSAMPLE_ZERO_FILL_EN
            out_data_d = '0;  // odd output column is a stuffed zero
`endif
          end else if (row_a_last_col) begin
            state_d    = ROW_B;
            rep_d      = 4'd0;
            dup_d      = 1'b0;
            out_data_d = replay_data;
          end else begin
            out_valid_d = 1'b0;
            dup_d       = 1'b0;
          end
        end
      end

      ROW_B: begin
        if (emit) begin
          if (!dup_q) begin
            dup_d      = 1'b1;
            out_last_d = (rep_q == LAST_IDX) && (row_q == LAST_IDX);
          end else if (rep_q == LAST_IDX) begin
            state_d     = ROW_A;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            dup_d       = 1'b0;
            rep_d       = 4'd0;
            row_d       = (row_q == LAST_IDX) ? 4'd0 : row_q + 4'd1;
          end else begin
            rep_d      = rep_q + 4'd1;
            dup_d      = 1'b0;
            out_data_d = replay_data;
          end
        end
      end

      default: state_d = ROW_A;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ROW_A;
      col_q       <= 4'd0;
      dup_q       <= 1'b0;
      rep_q       <= 4'd0;
      row_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      dup_q       <= dup_d;
      rep_q       <= rep_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.o_feature_valid = out_valid_q;
  assign bus.o_features      = out_data_q;
  assign bus.o_frame_last    = out_last_q;
endmodule

// File: tb/tb_upsample_2x.sv
// ---------------------------------------------------------------------------
// tb_upsample_2x -- scoreboard bench for upsample_2x.
// The driver pushes, per accepted input, the output beats it implies (taken
// directly from the out(r,c) = in(r/2,c/2) mapping, or zero-stuffing when
// UPSAMPLE_ZERO_FILL_EN is defined); a separate monitor pops and compares on
// every emit, and also checks stall stability and ready-low during replay.
// ---------------------------------------------------------------------------
module tb_upsample_2x;
  typedef logic [5:0][7:0] beat_t;
  typedef struct {
    beat_t data;
    logic  last;
    logic  odd;   // belongs to an odd (replayed) output row
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  upsample_2x_if bus ();

  upsample_2x dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int   total = 0;
  int   bad   = 0;
  bit   in_reset = 1'b1;
  exp_t exp_q[$];

  // reference model state: position in the 14x14 input frame
  beat_t row_store [14];
  int    m_row = 0;
  int    m_col = 0;

  // monitor state
  int    emits       = 0;
  int    frames_done = 0;
  bit    stalled     = 1'b0;
  beat_t held_data;
  logic  held_last;
  exp_t  mon_e;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Input (r,c) -> output row 2r cols 2c,2c+1 now; once a row is complete,
  // output row 2r+1 (28 beats) follows.
  task automatic model_accept(input beat_t v);
    exp_t e;
    row_store[m_col] = v;
    for (int d = 0; d < 2; d++) begin
`ifdef UPSAMPLE_ZERO_FILL_EN
      e.data = (d == 0) ? v : '0;
`else
      e.data = v;
`endif
      e.last = 1'b0;
      e.odd  = 1'b0;
      exp_q.push_back(e);
    end
    if (m_col == 13) begin
      for (int k = 0; k < 28; k++) begin
`ifdef UPSAMPLE_ZERO_FILL_EN
        e.data = '0;
`else
        e.data = row_store[k / 2];
`endif
        e.last = (m_row == 13) && (k == 27);
        e.odd  = 1'b1;
        exp_q.push_back(e);
      end
      m_col = 0;
      m_row = (m_row == 13) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  function automatic beat_t random_beat();
    beat_t b;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    return b;
  endfunction

  // Offer v until accepted; vp/rp are valid/ready percentages per cycle.
  task automatic send(input beat_t v, input int vp, input int rp);
    int guard = 0;
    forever begin
      @(negedge clk);
      bus.i_feature_ready = (int'($urandom_range(99)) < rp);
      bus.i_feature_valid = (int'($urandom_range(99)) < vp);
      bus.i_features      = v;
      #1;
      if (bus.i_feature_valid && bus.o_feature_ready) begin
        model_accept(v);
        break;
      end
      guard++;
      if (guard > 300) begin
        total++;
        bad++;
        $display("FAIL accept_timeout at %0t: no accept within 300 cycles", $time);
        finish_now();
      end
    end
  endtask

  task automatic idle(input int n, input int rp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_feature_valid = 1'b0;
      bus.i_feature_ready = (int'($urandom_range(99)) < rp);
    end
  endtask

  // Monitor: pops an expected beat on every emit.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (in_reset) begin
        emits   = 0;
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("hold_valid", 64'(bus.o_feature_valid), 64'd1);
        check("hold_data",  64'(bus.o_features), 64'(held_data));
        check("hold_last",  64'(bus.o_frame_last), 64'(held_last));
      end
      stalled   = bus.o_feature_valid && !bus.i_feature_ready;
      held_data = bus.o_features;
      held_last = bus.o_frame_last;
      if (bus.o_feature_valid && exp_q.size() > 0 && exp_q[0].odd)
        check("replay_ready_low", 64'(bus.o_feature_ready), 64'd0);
      if (bus.o_feature_valid && bus.i_feature_ready) begin
        emits++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat at %0t: got %0h, expected no beat", $time, bus.o_features);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data",  64'(bus.o_features), 64'(mon_e.data));
          check("frame_last", 64'(bus.o_frame_last), 64'(mon_e.last));
        end
        if (bus.o_frame_last) begin
          check("emits_per_frame", 64'(emits), 64'd784);
          emits = 0;
          frames_done++;
        end
      end
    end
  end

  // Stimulus
  initial begin
    beat_t v;
    int    guard;
    bus.i_feature_valid = 1'b0;
    bus.i_feature_ready = 1'b0;
    bus.i_features      = '0;

    #2;
    check("reset_valid", 64'(bus.o_feature_valid), 64'd0);
    check("reset_data",  64'(bus.o_features), 64'd0);
    check("reset_last",  64'(bus.o_frame_last), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 64'(bus.o_feature_ready), 64'd1);
    in_reset = 1'b0;

    // Rows 0-1 with downstream always ready; row 0 ch0 counts 1..14.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 14; c++) begin
        v = random_beat();
        if (r == 0) begin
`ifdef UPSAMPLE_ZERO_FILL_EN
          v[0] = (c == 0) ? 8'd5 : (c == 1) ? 8'd9 : 8'(c + 1);
`else
          v[0] = 8'(c + 1);
`endif
        end
        send(v, 100, 100);
      end
    end

    // Row 2: stall for three cycles while value 7 sits at its first copy.
    for (int c = 0; c < 3; c++) send(random_beat(), 100, 100);
    v    = random_beat();
    v[0] = 8'd7;
    send(v, 100, 100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_feature_valid = 1'b0;
      bus.i_feature_ready = 1'b0;
      #1;
      check("stall_valid", 64'(bus.o_feature_valid), 64'd1);
      check("stall_value", 64'(bus.o_features[0]), 64'd7);
    end

    // Remainder of frame 1 with random valid/ready.
    for (int i = 0; i < 196 - 32; i++) send(random_beat(), 80, 70);

    // Frame 2 row 0: corner values on col 0, then reset mid-replay.
    v = {8'hFB, 8'h05, 8'hFF, 8'h00, 8'h7F, 8'h80};  // ch5..ch0 = -5,5,-1,0,127,-128
    send(v, 100, 100);
    for (int c = 1; c < 14; c++) send(random_beat(), 100, 100);
    idle(8, 100);
    #1;
    check("in_replay_valid", 64'(bus.o_feature_valid), 64'd1);
    check("in_replay_ready", 64'(bus.o_feature_ready), 64'd0);

    @(posedge clk);
    #2;
    in_reset = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("async_reset_valid", 64'(bus.o_feature_valid), 64'd0);
    check("async_reset_data",  64'(bus.o_features), 64'd0);
    check("async_reset_last",  64'(bus.o_frame_last), 64'd0);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    idle(2, 100);
    rst_n = 1'b1;
    #1;
    check("ready_after_mid_reset", 64'(bus.o_feature_ready), 64'd1);
    in_reset = 1'b0;

    // Frame 3: full frame with random valid/ready, then drain.
    for (int i = 0; i < 196; i++) send(random_beat(), 85, 65);
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      idle(1, 70);
      guard++;
    end
    idle(3, 100);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("frames_completed", 64'(frames_done), 64'd2);
    finish_now();
  end
endmodule
